// File: rtl/flags_writer.sv
// ============================================================================
// Module  : flags_writer
// Purpose : Collects per-square matmul overflow flags into sticky bits and
//           issues a one-cycle write of the flags word when the operation ends.
//           Optional macro FLAGS_WRITER_COUNT_EN enables the flag popcount.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module flags_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  parameter int CNT_W      = $clog2(MAX_DIM * MAX_DIM) + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         valid_i,
  input  logic                         last_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]   ovf_i,
  output logic                         write_enable_o,
  output logic [BUS_WIDTH-1:0]         data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [CNT_W-1:0]             flag_count_o
);

  localparam int NFLAGS = MAX_DIM * MAX_DIM;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2
  } state_t;

  state_t               state_q;
  logic [NFLAGS-1:0]    sticky_q;
  logic [NFLAGS-1:0]    sticky_d;
  logic                 we_q;
  logic                 done_q;
  logic                 busy_q;
  logic [BUS_WIDTH-1:0] data_q;

  // Final flags word if the current beat is accepted.
  assign sticky_d = sticky_q | ovf_i;

`ifdef FLAGS_WRITER_COUNT_EN
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = '0;
    for (int k = 0; k < NFLAGS; k++) begin
      count_d = count_d + CNT_W'(sticky_d[k]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (state_q == S_COLLECT && !start_i && valid_i && last_i) begin
      count_q <= count_d;
    end
  end

  assign flag_count_o = count_q;
`else
  assign flag_count_o = '0;
`endif

  // Single-process FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      sticky_q <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      data_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q  <= S_COLLECT;
            sticky_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (start_i) begin
            sticky_q <= '0;
          end else if (valid_i) begin
            sticky_q <= sticky_d;
            if (last_i) begin
              state_q <= S_WRITE;
              we_q    <= 1'b1;
              done_q  <= 1'b1;
              data_q  <= BUS_WIDTH'(sticky_d);
            end
          end
        end
        S_WRITE: begin
          if (start_i) begin
            state_q  <= S_COLLECT;
            sticky_q <= '0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign write_enable_o = we_q;
  assign done_o         = done_q;
  assign busy_o         = busy_q;
  assign data_o         = data_q;

endmodule

`default_nettype wire

// File: tb/tb_flags_writer.sv
// ============================================================================
// Module  : tb_flags_writer
// Purpose : Directed self-checking bench for flags_writer (MAX_DIM=2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flags_writer;

  localparam int BUS_WIDTH = 64;
  localparam int CNT_W     = 3;
`ifdef FLAGS_WRITER_COUNT_EN
  localparam int COUNT_ON = 1;
`else
  localparam int COUNT_ON = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_i, start_i, valid_i, last_i;
  logic [3:0]           ovf_i;
  logic                 write_enable_o, busy_o, done_o;
  logic [BUS_WIDTH-1:0] data_o;
  logic [CNT_W-1:0]     flag_count_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  flags_writer dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .valid_i        (valid_i),
    .last_i         (last_i),
    .ovf_i          (ovf_i),
    .write_enable_o (write_enable_o),
    .data_o         (data_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .flag_count_o   (flag_count_o)
  );

  function automatic logic [CNT_W-1:0] ecnt(input int n);
    return (COUNT_ON != 0) ? CNT_W'(n) : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic v, input logic l, input logic [3:0] o);
    start_i = s; valid_i = v; last_i = l; ovf_i = o;
  endtask

  // ctl vector is {write_enable_o, done_o, busy_o}
  task automatic test_reset();
    rst_i = 1'b1;
    drive(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
    tick();
    drive(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
    tick();
    n_cmp++; if ({write_enable_o, done_o, busy_o} !== 3'b000) begin n_err++; $display("FAIL reset_ctl got %b want 000", {write_enable_o, done_o, busy_o}); end
    n_cmp++; if (data_o !== 64'h0) begin n_err++; $display("FAIL reset_data got %h want 0", data_o); end
    n_cmp++; if (flag_count_o !== 3'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", flag_count_o); end
    rst_i = 1'b0;
    drive(0, 0, 0, 4'h0);
    tick();
    n_cmp++; if ({write_enable_o, done_o, busy_o} !== 3'b000) begin n_err++; $display("FAIL reset_idle got %b want 000", {write_enable_o, done_o, busy_o}); end
  endtask

  task automatic test_basic();
    drive(1, 0, 0, 4'h0); tick();
    n_cmp++; if ({write_enable_o, done_o, busy_o} !== 3'b001) begin n_err++; $display("FAIL basic_start got %b want 001", {write_enable_o, done_o, busy_o}); end
    drive(0, 1, 0, 4'b0001); tick();
    n_cmp++; if ({write_enable_o, done_o, busy_o} !== 3'b001) begin n_err++; $display("FAIL basic_beat got %b want 001", {write_enable_o, done_o, busy_o}); end
    drive(0, 1, 1, 4'b0100); tick();
    n_cmp++; if ({write_enable_o, done_o, busy_o} !== 3'b111) begin n_err++; $display("FAIL basic_wr_ctl got %b want 111", {write_enable_o, done_o, busy_o}); end
    n_cmp++; if (data_o !== 64'h5) begin n_err++; $display("FAIL basic_data got %h want 5", data_o); end
    n_cmp++; if (flag_count_o !== ecnt(2)) begin n_err++; $display("FAIL basic_cnt got %0d want %0d", flag_count_o, ecnt(2)); end
    drive(0, 0, 0, 4'h0); tick();
    n_cmp++; if ({write_enable_o, done_o, busy_o} !== 3'b000) begin n_err++; $display("FAIL basic_after got %b want 000", {write_enable_o, done_o, busy_o}); end
    n_cmp++; if (data_o !== 64'h0) begin n_err++; $display("FAIL basic_data_zero got %h want 0", data_o); end
    n_cmp++; if (flag_count_o !== ecnt(2)) begin n_err++; $display("FAIL basic_cnt_hold got %0d want %0d", flag_count_o, ecnt(2)); end
  endtask

  task automatic test_ignored();
    drive(0, 1, 1, 4'b1111); tick();
    n_cmp++; if ({write_enable_o, done_o, busy_o} !== 3'b000) begin n_err++; $display("FAIL ign_idle got %b want 000", {write_enable_o, done_o, busy_o}); end
    drive(1, 0, 0, 4'h0); tick();
    drive(0, 0, 1, 4'b1111); tick();
    n_cmp++; if ({write_enable_o, done_o, busy_o} !== 3'b001) begin n_err++; $display("FAIL ign_last_only got %b want 001", {write_enable_o, done_o, busy_o}); end
    drive(0, 1, 1, 4'h0); tick();
    n_cmp++; if ({write_enable_o, done_o, busy_o} !== 3'b111) begin n_err++; $display("FAIL ign_wr_ctl got %b want 111", {write_enable_o, done_o, busy_o}); end
    n_cmp++; if (data_o !== 64'h0) begin n_err++; $display("FAIL ign_data got %h want 0", data_o); end
    n_cmp++; if (flag_count_o !== 3'd0) begin n_err++; $display("FAIL ign_cnt got %0d want 0", flag_count_o); end
    drive(0, 0, 0, 4'h0); tick();
  endtask

  task automatic test_restart();
    drive(1, 0, 0, 4'h0); tick();
    drive(0, 1, 0, 4'b0010); tick();
    drive(1, 1, 0, 4'b0001); tick();
    n_cmp++; if ({write_enable_o, done_o, busy_o} !== 3'b001) begin n_err++; $display("FAIL rst_restart got %b want 001", {write_enable_o, done_o, busy_o}); end
    drive(0, 1, 1, 4'b1000); tick();
    n_cmp++; if (write_enable_o !== 1'b1) begin n_err++; $display("FAIL restart_we got %b want 1", write_enable_o); end
    n_cmp++; if (data_o !== 64'h8) begin n_err++; $display("FAIL restart_data got %h want 8", data_o); end
    n_cmp++; if (flag_count_o !== ecnt(1)) begin n_err++; $display("FAIL restart_cnt got %0d want %0d", flag_count_o, ecnt(1)); end
    drive(0, 0, 0, 4'h0); tick();
  endtask

  task automatic test_abort();
    drive(1, 0, 0, 4'h0); tick();
    drive(0, 1, 0, 4'b1111); tick();
    rst_i = 1'b1; drive(0, 0, 0, 4'h0); tick();
    n_cmp++; if ({write_enable_o, done_o, busy_o} !== 3'b000) begin n_err++; $display("FAIL abort_rst got %b want 000", {write_enable_o, done_o, busy_o}); end
    n_cmp++; if (flag_count_o !== 3'd0) begin n_err++; $display("FAIL abort_cnt got %0d want 0", flag_count_o); end
    rst_i = 1'b0;
    drive(0, 1, 1, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({write_enable_o, done_o, busy_o} !== 3'b000) begin n_err++; $display("FAIL abort_nowr[%0d] got %b want 000", i, {write_enable_o, done_o, busy_o}); end
    end
    drive(0, 0, 0, 4'h0); tick();
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, 4'h0); tick();
    drive(0, 1, 1, 4'b0011); tick();
    n_cmp++; if ({write_enable_o, done_o, busy_o} !== 3'b111) begin n_err++; $display("FAIL b2b_wr1_ctl got %b want 111", {write_enable_o, done_o, busy_o}); end
    n_cmp++; if (data_o !== 64'h3) begin n_err++; $display("FAIL b2b_data1 got %h want 3", data_o); end
    n_cmp++; if (flag_count_o !== ecnt(2)) begin n_err++; $display("FAIL b2b_cnt1 got %0d want %0d", flag_count_o, ecnt(2)); end
    drive(1, 0, 0, 4'h0); tick();
    n_cmp++; if ({write_enable_o, done_o, busy_o} !== 3'b001) begin n_err++; $display("FAIL b2b_gap got %b want 001", {write_enable_o, done_o, busy_o}); end
    drive(0, 1, 1, 4'b1000); tick();
    n_cmp++; if ({write_enable_o, done_o, busy_o} !== 3'b111) begin n_err++; $display("FAIL b2b_wr2_ctl got %b want 111", {write_enable_o, done_o, busy_o}); end
    n_cmp++; if (data_o !== 64'h8) begin n_err++; $display("FAIL b2b_data2 got %h want 8", data_o); end
    n_cmp++; if (flag_count_o !== ecnt(1)) begin n_err++; $display("FAIL b2b_cnt2 got %0d want %0d", flag_count_o, ecnt(1)); end
    drive(0, 0, 0, 4'h0); tick();
    n_cmp++; if ({write_enable_o, done_o, busy_o} !== 3'b000) begin n_err++; $display("FAIL b2b_end got %b want 000", {write_enable_o, done_o, busy_o}); end
  endtask

  initial begin
    rst_i = 1'b1;
    drive(0, 0, 0, 4'h0);
    test_reset();
    test_basic();
    test_ignored();
    test_restart();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
